// File: rtl/memio_pkg.sv
// Shared types and constants for the SLC-3 memory / memory-mapped I/O controller.
package memio_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        IO    = 3'd4
    } state_t;

    localparam int unsigned WAIT_CNT_W = 4;

    // Switch/hex register sits at the all-ones address of an aw-bit space.
    function automatic logic [31:0] sw_hex_addr(input int unsigned aw);
        return (aw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
    endfunction

    function automatic logic [31:0] led_addr(input int unsigned aw);
        return sw_hex_addr(aw) - 32'd1;
    endfunction

endpackage

// File: rtl/mem_io_ctrl_if.sv
// CPU-side request/acknowledge bus between the control unit and mem_io_ctrl.
interface mem_io_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;

    modport master (output req, we, addr, wdata, input rdata, ack, busy);
    modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/memio_sync.sv
// Parametrised two-flop synchroniser with a configurable reset value.
module memio_sync #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/mem_io_ctrl.sv
// Memory and memory-mapped I/O controller: async SRAM with wait states, switches, hex, LEDs.
// Define MEMIO_LED_EN to map the LED register at address all-ones-1.
module mem_io_ctrl
    import memio_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned SRAM_ADDR_W = 20,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned NUM_HEX     = 4,
    parameter int unsigned SW_W        = 16,
    parameter int unsigned LED_W       = 12
) (
    input  logic                   Clk,
    input  logic                   Reset,
    mem_io_ctrl_if.slave           bus,
    input  logic [SW_W-1:0]        Switches,
    output logic [4*NUM_HEX-1:0]   hex_digits,
    output logic [LED_W-1:0]       LED,
    output logic                   CE,
    output logic                   OE,
    output logic                   WE,
    output logic                   UB,
    output logic                   LB,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic [DATA_W-1:0]      Data_write,
    input  logic [DATA_W-1:0]      Data_read,
    output logic                   Data_oe
);
    localparam logic [ADDR_W-1:0] SW_HEX_ADDR = ADDR_W'(sw_hex_addr(ADDR_W));

    state_t                  state, state_d;
    logic [WAIT_CNT_W-1:0]   cnt, cnt_d;
    logic [ADDR_W-1:0]       a_q;
    logic                    we_q;
    logic [SW_W-1:0]         sw_sync, sw_snap;
    logic                    io_hit, accept, acc_we;
    logic [DATA_W-1:0]       io_rdata;

    logic                    ce_d, oe_d, we_d, ub_d, lb_d, data_oe_d, ack_d, busy_d;
    logic [DATA_W-1:0]       rdata_d;
    logic [4*NUM_HEX-1:0]    hex_d;
    logic [SRAM_ADDR_W-1:0]  sram_addr_d;

    memio_sync #(.W(SW_W), .RST_VAL('0)) u_sw_sync (
        .clk (Clk),
        .rst (Reset),
        .d   (Switches),
        .q   (sw_sync)
    );

    assign accept   = (state == IDLE) && bus.req;
    assign acc_we   = accept ? bus.we : we_q;
    assign io_rdata = (a_q == SW_HEX_ADDR) ? DATA_W'(sw_snap) : '0;

`ifdef MEMIO_LED_EN
    localparam logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(led_addr(ADDR_W));

    assign io_hit = (bus.addr == SW_HEX_ADDR) || (bus.addr == LED_ADDR);

    always_ff @(posedge Clk) begin
        if (Reset)
            LED <= '0;
        else if (state == IO && we_q && a_q == LED_ADDR)
            LED <= Data_write[LED_W-1:0];
    end
`else
    assign io_hit = (bus.addr == SW_HEX_ADDR);
    assign LED    = '0;
`endif

    // State register plus the wait-state counter and latched request.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            a_q        <= '0;
            we_q       <= 1'b0;
            sw_snap    <= '0;
            Data_write <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                a_q        <= bus.addr;
                we_q       <= bus.we;
                sw_snap    <= sw_sync;
                Data_write <= bus.wdata;
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE:  if (bus.req) state_d = io_hit ? IO : SETUP;
            SETUP: begin
                state_d = WAIT;
                cnt_d   = WAIT_CNT_W'(WAIT_STATES);
            end
            WAIT: begin
                if (cnt == '0) state_d = DONE;
                else           cnt_d   = cnt - WAIT_CNT_W'(1);
            end
            DONE:    state_d = IDLE;
            IO:      state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed for the upcoming state so every pin comes straight from a flop.
    always_comb begin
        ce_d        = 1'b1;
        oe_d        = 1'b1;
        we_d        = 1'b1;
        ub_d        = 1'b1;
        lb_d        = 1'b1;
        data_oe_d   = 1'b0;
        ack_d       = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        rdata_d     = bus.rdata;
        hex_d       = hex_digits;
        sram_addr_d = SRAM_ADDR;
        case (state_d)
            SETUP, WAIT: begin
                ce_d      = 1'b0;
                ub_d      = 1'b0;
                lb_d      = 1'b0;
                oe_d      = acc_we;
                data_oe_d = acc_we;
                if (state_d == WAIT) we_d = ~acc_we;
            end
            // Data_oe outlasts WE by one cycle for write-data hold.
            DONE:    data_oe_d = we_q && (state == WAIT);
            default: ;
        endcase
        if (accept && !io_hit)
            sram_addr_d = SRAM_ADDR_W'(bus.addr);
        if (state == WAIT && state_d == DONE && !we_q)
            rdata_d = Data_read;
        if (state == IO && !we_q)
            rdata_d = io_rdata;
        if (state == IO && we_q && a_q == SW_HEX_ADDR)
            hex_d = Data_write[4*NUM_HEX-1:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            CE         <= 1'b1;
            OE         <= 1'b1;
            WE         <= 1'b1;
            UB         <= 1'b1;
            LB         <= 1'b1;
            Data_oe    <= 1'b0;
            bus.ack    <= 1'b0;
            bus.busy   <= 1'b0;
            bus.rdata  <= '0;
            hex_digits <= '0;
            SRAM_ADDR  <= '0;
        end else begin
            CE         <= ce_d;
            OE         <= oe_d;
            WE         <= we_d;
            UB         <= ub_d;
            LB         <= lb_d;
            Data_oe    <= data_oe_d;
            bus.ack    <= ack_d;
            bus.busy   <= busy_d;
            bus.rdata  <= rdata_d;
            hex_digits <= hex_d;
            SRAM_ADDR  <= sram_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl: default 16-bit instance plus two 32-bit/8-digit instances.
module tb_mem_io_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- default instance (16-bit, 1 wait state) ----------------
    mem_io_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();
    logic [15:0] sw0;
    logic [15:0] hex0;
    logic [11:0] led0;
    logic        ce0, oe0, we0, ub0, lb0, doe0;
    logic [19:0] sa0;
    logic [15:0] dw0, dr0;

    mem_io_ctrl #(
        .DATA_W(16), .ADDR_W(16), .SRAM_ADDR_W(20), .WAIT_STATES(1),
        .NUM_HEX(4), .SW_W(16), .LED_W(12)
    ) u_dut0 (
        .Clk(clk), .Reset(rst), .bus(bus0), .Switches(sw0), .hex_digits(hex0), .LED(led0),
        .CE(ce0), .OE(oe0), .WE(we0), .UB(ub0), .LB(lb0), .SRAM_ADDR(sa0),
        .Data_write(dw0), .Data_read(dr0), .Data_oe(doe0)
    );

    logic [15:0] mem0 [0:65535];
    assign dr0 = (!ce0 && !oe0) ? mem0[sa0[15:0]] : 16'hDEAD;
    always @(posedge clk) if (!ce0 && !we0) mem0[sa0[15:0]] <= dw0;

    int we_low0 = 0, ce_low0 = 0, ack_cnt0 = 0, doe_cnt0 = 0, oe_gap0 = 0;
    always @(negedge clk) begin
        if (!we0)          we_low0  <= we_low0 + 1;
        if (!ce0)          ce_low0  <= ce_low0 + 1;
        if (bus0.ack)      ack_cnt0 <= ack_cnt0 + 1;
        if (doe0)          doe_cnt0 <= doe_cnt0 + 1;
        if (!we0 && !doe0) oe_gap0  <= oe_gap0 + 1;
    end

    // ---------------- 32-bit instances: 0 and 5 wait states ----------------
    mem_io_ctrl_if #(.DATA_W(32), .ADDR_W(16)) bus_a ();
    mem_io_ctrl_if #(.DATA_W(32), .ADDR_W(16)) bus_b ();
    logic [15:0] sw32;
    logic [31:0] hex_a, hex_b, dw_a, dw_b, dr_a, dr_b;
    logic [11:0] led_a, led_b;
    logic        ce_a, oe_a, we_a, ub_a, lb_a, doe_a;
    logic        ce_b, oe_b, we_b, ub_b, lb_b, doe_b;
    logic [19:0] sa_a, sa_b;

    mem_io_ctrl #(
        .DATA_W(32), .ADDR_W(16), .SRAM_ADDR_W(20), .WAIT_STATES(0),
        .NUM_HEX(8), .SW_W(16), .LED_W(12)
    ) u_dut_a (
        .Clk(clk), .Reset(rst), .bus(bus_a), .Switches(sw32), .hex_digits(hex_a), .LED(led_a),
        .CE(ce_a), .OE(oe_a), .WE(we_a), .UB(ub_a), .LB(lb_a), .SRAM_ADDR(sa_a),
        .Data_write(dw_a), .Data_read(dr_a), .Data_oe(doe_a)
    );

    mem_io_ctrl #(
        .DATA_W(32), .ADDR_W(16), .SRAM_ADDR_W(20), .WAIT_STATES(5),
        .NUM_HEX(8), .SW_W(16), .LED_W(12)
    ) u_dut_b (
        .Clk(clk), .Reset(rst), .bus(bus_b), .Switches(sw32), .hex_digits(hex_b), .LED(led_b),
        .CE(ce_b), .OE(oe_b), .WE(we_b), .UB(ub_b), .LB(lb_b), .SRAM_ADDR(sa_b),
        .Data_write(dw_b), .Data_read(dr_b), .Data_oe(doe_b)
    );

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    assign dr_a = (!ce_a && !oe_a) ? mem_a[sa_a[7:0]] : 32'hDEAD_0000;
    assign dr_b = (!ce_b && !oe_b) ? mem_b[sa_b[7:0]] : 32'hDEAD_0000;
    always @(posedge clk) if (!ce_a && !we_a) mem_a[sa_a[7:0]] <= dw_a;
    always @(posedge clk) if (!ce_b && !we_b) mem_b[sa_b[7:0]] <= dw_b;

    // One access on the default instance; lat = cycles from req cycle to ack cycle (0 = timeout).
    task automatic access0(input logic w, input logic [15:0] a, input logic [15:0] d,
                           output int lat, output logic [15:0] rd, output logic [19:0] sa);
        lat = 0; rd = '0; sa = '0;
        bus0.req = 1'b1; bus0.we = w; bus0.addr = a; bus0.wdata = d;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) sa = sa0;
            if (bus0.ack) begin
                lat = i; rd = bus0.rdata;
                break;
            end
        end
        bus0.req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic acc32(input logic w, input logic [15:0] a, input logic [31:0] d,
                         output int la, output int lb, output logic [31:0] ra, output logic [31:0] rb);
        la = 0; lb = 0; ra = '0; rb = '0;
        bus_a.req = 1'b1; bus_a.we = w; bus_a.addr = a; bus_a.wdata = d;
        bus_b.req = 1'b1; bus_b.we = w; bus_b.addr = a; bus_b.wdata = d;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus_a.ack && la == 0) begin la = i; ra = bus_a.rdata; bus_a.req = 1'b0; end
            if (bus_b.ack && lb == 0) begin lb = i; rb = bus_b.rdata; bus_b.req = 1'b0; end
            if (la != 0 && lb != 0) break;
        end
        bus_a.req = 1'b0; bus_b.req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat, la, lb, snap_we, snap_ce, snap_ack, snap_doe;
        logic [15:0] rd, mem_keep;
        logic [19:0] sa;
        logic [31:0] ra, rb;

        rst = 1'b1;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
        bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
        bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;
        sw0 = 16'h0000; sw32 = 16'h0000;
        repeat (3) @(posedge clk);
        #1;

        check("rst_strobes", 64'({ce0, oe0, we0, ub0, lb0}), 64'(5'b11111));
        check("rst_flags",   64'({doe0, bus0.ack, bus0.busy}), 64'(3'b000));
        check("rst_regs",    64'({bus0.rdata, hex0, sa0}), 64'd0);
        check("rst_led",     64'(led0), 64'd0);

        rst = 1'b0;
        @(posedge clk); #1;

        // Reset arriving during the WAIT phase of a write abandons it.
        bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 16'h0010; bus0.wdata = 16'h5555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mw_in_wait", 64'({ce0, we0, doe0, bus0.busy}), 64'(4'b0011));
        rst = 1'b1; bus0.req = 1'b0;
        snap_ack = ack_cnt0;
        @(posedge clk); #1;
        check("mw_after_rst", 64'({ce0, we0, doe0, bus0.busy, bus0.ack}), 64'(5'b11000));
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mw_no_ack", 64'(ack_cnt0), 64'(snap_ack));
        access0(1'b0, 16'h0010, 16'h0000, lat, rd, sa);
        check("mw_read_lat", 64'(lat), 64'd4);
        check("mw_read_data", 64'(rd), 64'(mem0[16'h0010]));

        // SRAM write/read with one wait state.
        snap_we = we_low0; snap_doe = doe_cnt0;
        access0(1'b1, 16'h1234, 16'hBEEF, lat, rd, sa);
        check("wr_lat", 64'(lat), 64'd4);
        check("wr_addr", 64'(sa), 64'h01234);
        check("wr_we_cycles", 64'(we_low0 - snap_we), 64'd2);
        check("wr_doe_cycles", 64'(doe_cnt0 - snap_doe), 64'd4);
        check("wr_mem", 64'(mem0[16'h1234]), 64'hBEEF);
        access0(1'b0, 16'h1234, 16'h0000, lat, rd, sa);
        check("rd_lat", 64'(lat), 64'd4);
        check("rd_addr", 64'(sa), 64'h01234);
        check("rd_data", 64'(rd), 64'hBEEF);

        // Hex write: I/O path, no SRAM strobes, rdata untouched.
        snap_ce = ce_low0;
        access0(1'b1, 16'hFFFF, 16'hA5C3, lat, rd, sa);
        check("hex_lat", 64'(lat), 64'd2);
        check("hex_no_ce", 64'(ce_low0 - snap_ce), 64'd0);
        check("hex_val", 64'(hex0), 64'hA5C3);
        check("rdata_hold", 64'(bus0.rdata), 64'hBEEF);

        // Switch reads through the synchroniser.
        sw0 = 16'h0F0F;
        repeat (2) @(posedge clk);
        #1;
        access0(1'b0, 16'hFFFF, 16'h0000, lat, rd, sa);
        check("sw_lat", 64'(lat), 64'd2);
        check("sw_read", 64'(rd), 64'h0F0F);
        sw0 = 16'h1111;
        @(posedge clk); #1;
        access0(1'b0, 16'hFFFF, 16'h0000, lat, rd, sa);
        check("sw_late_change", 64'(rd), 64'h0F0F);
        access0(1'b0, 16'hFFFF, 16'h0000, lat, rd, sa);
        check("sw_new_value", 64'(rd), 64'h1111);

`ifdef MEMIO_LED_EN
        mem_keep = mem0[16'hFFFE];
        access0(1'b1, 16'hFFFE, 16'h0ABC, lat, rd, sa);
        check("led_wr_lat", 64'(lat), 64'd2);
        check("led_val", 64'(led0), 64'hABC);
        check("led_sram_kept", 64'(mem0[16'hFFFE]), 64'(mem_keep));
        access0(1'b0, 16'hFFFE, 16'h0000, lat, rd, sa);
        check("led_read_zero", 64'(rd), 64'd0);
`else
        mem_keep = 16'h0ABC;
        access0(1'b1, 16'hFFFE, 16'h0ABC, lat, rd, sa);
        check("led_wr_lat", 64'(lat), 64'd4);
        check("led_tied", 64'(led0), 64'd0);
        check("led_sram_mem", 64'(mem0[16'hFFFE]), 64'(mem_keep));
        access0(1'b0, 16'hFFFE, 16'h0000, lat, rd, sa);
        check("led_sram_read", 64'(rd), 64'h0ABC);
`endif
        check("we_without_doe", 64'(oe_gap0), 64'd0);

        // Width / wait-state sweep.
        acc32(1'b1, 16'h0042, 32'h1234_5678, la, lb, ra, rb);
        check("w0_wr_lat", 64'(la), 64'd3);
        check("w5_wr_lat", 64'(lb), 64'd8);
        acc32(1'b0, 16'h0042, 32'h0, la, lb, ra, rb);
        check("w0_rd_lat", 64'(la), 64'd3);
        check("w5_rd_lat", 64'(lb), 64'd8);
        check("w0_rd_data", 64'(ra), 64'h1234_5678);
        check("w5_rd_data", 64'(rb), 64'h1234_5678);
        acc32(1'b1, 16'hFFFF, 32'h89AB_CDEF, la, lb, ra, rb);
        check("w32_hex_lat", 64'({la[7:0], lb[7:0]}), 64'h0202);
        check("w32_hex_vals", {hex_a, hex_b}, 64'h89AB_CDEF_89AB_CDEF);
        check("w32_idle", 64'({ce_a, oe_a, we_a, ub_a, lb_a, doe_a, ce_b, oe_b, we_b, ub_b, lb_b, doe_b}),
              64'(12'b111110_111110));
        check("w32_led", 64'({led_a, led_b}), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
